game_board_move_engine: RTL



---
 rtl/game_board_move_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/game_board_move_engine.sv
// 2048 move engine: captures a GRID_N x GRID_N board, slides/merges one line per clock.
// Optional tile spawn after a move is enabled by defining GAME_MOVE_SPAWN_EN.
//
// state | meaning
// IDLE  | waiting for start; also the done cycle (busy still high)
// LINE  | processing line i, one line per clock
// SPAWN | place a random tile if the board moved (GAME_MOVE_SPAWN_EN only)
// DONE  | publish board_out/moved/score_delta and pulse done
module game_board_move_engine #(
   parameter int GRID_N  = 4,
   parameter int CELL_W  = 4,
   parameter int SCORE_W = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [1:0]                      direction,
   input  logic [GRID_N*GRID_N*CELL_W-1:0] board_in,
   output logic                            busy,
   output logic                            done,
   output logic [GRID_N*GRID_N*CELL_W-1:0] board_out,
   output logic                            moved,
   output logic [SCORE_W-1:0]              score_delta
);

   localparam int NN = GRID_N * GRID_N;
   localparam int BW = NN * CELL_W;
   localparam int IW = $clog2(GRID_N);
   localparam logic [CELL_W-1:0] CELL_MAX = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LINE  = 2'd1;
`ifdef GAME_MOVE_SPAWN_EN
   localparam logic [1:0] S_SPAWN = 2'd2;
`endif
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state;
   logic [IW-1:0]      line_i;
   logic [1:0]         dir_q;
   logic [BW-1:0]      work;
   logic [BW-1:0]      work_next;
   logic               moved_acc;
   logic [SCORE_W-1:0] score_acc;

   logic [CELL_W-1:0]  line_in  [GRID_N];
   logic [CELL_W-1:0]  comp     [GRID_N+1];
   logic [CELL_W-1:0]  line_out [GRID_N];
   logic [SCORE_W-1:0] line_score;
   logic               line_moved;
   int                 cnt, k, o;

   // Position p counts outward from the destination edge of line ln.
   function automatic int cell_idx(input logic [1:0] d, input int ln, input int p);
      case (d)
         2'd0:    return ln * GRID_N + p;
         2'd1:    return ln * GRID_N + (GRID_N - 1 - p);
         2'd2:    return p * GRID_N + ln;
         default: return (GRID_N - 1 - p) * GRID_N + ln;
      endcase
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

   function automatic logic [SCORE_W-1:0] pow2_sat(input logic [CELL_W-1:0] v);
      logic [SCORE_W-1:0] one;
      one = 1;
      if (int'(v) >= SCORE_W) return '1;
      return one << v;
   endfunction

   always_comb begin
      work_next  = work;
      line_score = '0;
      line_moved = 1'b0;
      cnt = 0;
      k   = 0;
      o   = 0;
      for (int p = 0; p <= GRID_N; p++) comp[p] = '0;
      for (int p = 0; p < GRID_N; p++) begin
         line_in[p]  = work[cell_idx(dir_q, int'(line_i), p)*CELL_W +: CELL_W];
         line_out[p] = '0;
      end
      for (int p = 0; p < GRID_N; p++) begin
         if (line_in[p] != '0) begin
            comp[cnt] = line_in[p];
            cnt++;
         end
      end
      // Each output slot consumes one or two compacted cells, so GRID_N passes suffice.
      for (int p = 0; p < GRID_N; p++) begin
         if (k < cnt) begin
            if ((k + 1 < cnt) && (comp[k] == comp[k+1]) && (comp[k] != CELL_MAX)) begin
               line_out[o] = comp[k] + 1'b1;
               line_score  = sat_add(line_score, pow2_sat(comp[k] + 1'b1));
               k += 2;
            end else begin
               line_out[o] = comp[k];
               k += 1;
            end
            o++;
         end
      end
      for (int p = 0; p < GRID_N; p++) begin
         if (line_out[p] != line_in[p]) line_moved = 1'b1;
         work_next[cell_idx(dir_q, int'(line_i), p)*CELL_W +: CELL_W] = line_out[p];
      end
   end

`ifdef GAME_MOVE_SPAWN_EN
   logic [15:0]   lfsr;
   logic [BW-1:0] spawn_board;
   logic          spawn_found;
   int            spawn_pos;
   int            spawn_base;
   int            q_pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   always_comb begin
      spawn_board = work;
      spawn_found = 1'b0;
      spawn_pos   = 0;
      spawn_base  = int'(lfsr[5:0]) % NN;
      q_pos       = 0;
      for (int q = 0; q < NN; q++) begin
         q_pos = (spawn_base + q) % NN;
         if (!spawn_found && (work[q_pos*CELL_W +: CELL_W] == '0)) begin
            spawn_found = 1'b1;
            spawn_pos   = q_pos;
         end
      end
      if (moved_acc && spawn_found)
         spawn_board[spawn_pos*CELL_W +: CELL_W] = (lfsr[9:6] == 4'd0) ? CELL_W'(2) : CELL_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         line_i      <= '0;
         dir_q       <= 2'd0;
         work        <= '0;
         moved_acc   <= 1'b0;
         score_acc   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         board_out   <= '0;
         moved       <= 1'b0;
         score_delta <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // busy still high here means this is the done cycle; start is ignored.
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  work      <= board_in;
                  dir_q     <= direction;
                  moved_acc <= 1'b0;
                  score_acc <= '0;
                  line_i    <= '0;
                  busy      <= 1'b1;
                  state     <= S_LINE;
               end
            end
            S_LINE: begin
               work      <= work_next;
               moved_acc <= moved_acc | line_moved;
               score_acc <= sat_add(score_acc, line_score);
               if (line_i == IW'(GRID_N - 1)) begin
`ifdef GAME_MOVE_SPAWN_EN
                  state <= S_SPAWN;
`else
                  state <= S_DONE;
`endif
               end else begin
                  line_i <= line_i + 1'b1;
               end
            end
`ifdef GAME_MOVE_SPAWN_EN
            S_SPAWN: begin
               work  <= spawn_board;
               state <= S_DONE;
            end
`endif
            S_DONE: begin
               board_out   <= work;
               moved       <= moved_acc;
               score_delta <= score_acc;
               done        <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
